// File: rtl/text_console_ctrl.sv
// rtl/text_console_ctrl.sv - byte-stream text console sequencer owning the VRAM write port
`ifndef DP_REG_WIDTH
`define DP_REG_WIDTH 16
`endif

module text_console_ctrl #(
   parameter int         COLS       = 80,
   parameter int         ROWS       = 30,
   parameter logic [7:0] BLANK_CHAR = 8'h20
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      ch_valid,
   input  logic [7:0]                ch_data,
   output logic                      ch_ready,
   input  logic [7:0]                attr,
   input  logic                      clr_req,
   output logic                      busy,
   output logic                      vram_we,
   output logic [7:0]                vram_x,
   output logic [4:0]                vram_y,
   output logic [15:0]               vram_wdata,
   output logic                      vram_re,
   output logic [7:0]                vram_rx,
   output logic [4:0]                vram_ry,
   input  logic [15:0]               vram_rdata,
   output logic [`DP_REG_WIDTH-1:0]  ctrl_reg
);
   localparam int         REG_W = `DP_REG_WIDTH;
   localparam logic [7:0] X_MAX = 8'(COLS - 1);
   localparam logic [4:0] Y_MAX = 5'(ROWS - 1);

   typedef enum logic [2:0] {IDLE, PUT, CLEAR, SCR_RD, SCR_WR, SCR_FILL} state_t;

   state_t           state_q;
   logic [7:0]       cx_q, sx_q, wx_q, attr_q;
   logic [4:0]       cy_q, sy_q, wy_q;
   logic [15:0]      wdata_q;
   logic             we_q, re_q, scroll_q;
   logic [REG_W-1:0] ctrl_q;

   logic             put_we_d, scroll_d, is_bs;
   logic [7:0]       cx_d, put_char_d;
   logic [4:0]       cy_d;

   // Cursor move and cell write for the byte being accepted this cycle.
   always_comb begin
      put_we_d   = 1'b0;
      scroll_d   = 1'b0;
      cx_d       = cx_q;
      cy_d       = cy_q;
      put_char_d = ch_data;
      is_bs      = (ch_data == 8'h08);
      case (ch_data)
         8'h0D: cx_d = '0;
         8'h0A: begin
            cx_d = '0;
            if (cy_q == Y_MAX) scroll_d = 1'b1;
            else               cy_d     = cy_q + 5'd1;
         end
         8'h08: begin
            put_char_d = BLANK_CHAR;
            if (cx_q != 8'd0) begin
               cx_d     = cx_q - 8'd1;
               put_we_d = 1'b1;
            end else if (cy_q != 5'd0) begin
               cx_d     = X_MAX;
               cy_d     = cy_q - 5'd1;
               put_we_d = 1'b1;
            end
         end
         default: begin
            put_we_d = 1'b1;
            if (cx_q == X_MAX) begin
               cx_d = '0;
               if (cy_q == Y_MAX) scroll_d = 1'b1;
               else               cy_d     = cy_q + 5'd1;
            end else begin
               cx_d = cx_q + 8'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cx_q     <= '0;
         cy_q     <= '0;
         sx_q     <= '0;
         sy_q     <= '0;
         wx_q     <= '0;
         wy_q     <= '0;
         attr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         re_q     <= 1'b0;
         scroll_q <= 1'b0;
         ctrl_q   <= '0;
      end else begin
         we_q   <= 1'b0;
         re_q   <= 1'b0;
         ctrl_q <= REG_W'({cy_q, cx_q});
         case (state_q)
            IDLE: begin
               if (clr_req) begin
                  state_q <= CLEAR;
                  attr_q  <= attr;
                  we_q    <= 1'b1;
                  wx_q    <= '0;
                  wy_q    <= '0;
                  wdata_q <= {attr, BLANK_CHAR};
               end else if (ch_valid) begin
                  state_q  <= PUT;
                  attr_q   <= attr;
                  cx_q     <= cx_d;
                  cy_q     <= cy_d;
                  scroll_q <= scroll_d;
                  we_q     <= put_we_d;
                  wx_q     <= is_bs ? cx_d : cx_q;
                  wy_q     <= is_bs ? cy_d : cy_q;
                  wdata_q  <= {attr, put_char_d};
               end
            end
            PUT: begin
               if (scroll_q) begin
                  state_q <= SCR_RD;
                  sx_q    <= '0;
                  sy_q    <= 5'd1;
                  re_q    <= 1'b1;
               end else begin
                  state_q <= IDLE;
               end
            end
            CLEAR: begin
               if (wx_q == X_MAX && wy_q == Y_MAX) begin
                  state_q <= IDLE;
                  cx_q    <= '0;
                  cy_q    <= '0;
               end else begin
                  we_q <= 1'b1;
                  if (wx_q == X_MAX) begin
                     wx_q <= '0;
                     wy_q <= wy_q + 5'd1;
                  end else begin
                     wx_q <= wx_q + 8'd1;
                  end
               end
            end
            SCR_RD: begin
               state_q <= SCR_WR;
               we_q    <= 1'b1;
               wx_q    <= sx_q;
               wy_q    <= sy_q - 5'd1;
            end
            SCR_WR: begin
               if (sx_q == X_MAX) begin
                  sx_q <= '0;
                  if (sy_q == Y_MAX) begin
                     state_q <= SCR_FILL;
                     we_q    <= 1'b1;
                     wx_q    <= '0;
                     wy_q    <= Y_MAX;
                     wdata_q <= {attr_q, BLANK_CHAR};
                  end else begin
                     sy_q    <= sy_q + 5'd1;
                     state_q <= SCR_RD;
                     re_q    <= 1'b1;
                  end
               end else begin
                  sx_q    <= sx_q + 8'd1;
                  state_q <= SCR_RD;
                  re_q    <= 1'b1;
               end
            end
            SCR_FILL: begin
               if (wx_q == X_MAX) begin
                  state_q <= IDLE;
               end else begin
                  wx_q <= wx_q + 8'd1;
                  we_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Copy data arrives one cycle after the read strobe, so it bypasses the write register.
   assign vram_wdata = (state_q == SCR_WR) ? vram_rdata : wdata_q;
   assign vram_we    = we_q;
   assign vram_x     = wx_q;
   assign vram_y     = wy_q;
   assign vram_re    = re_q;
   assign vram_rx    = sx_q;
   assign vram_ry    = sy_q;
   assign busy       = (state_q != IDLE);
   assign ch_ready   = reset_n && (state_q == IDLE) && !clr_req;
   assign ctrl_reg   = ctrl_q;

endmodule

// File: tb/tb_text_console_ctrl.sv
// tb/tb_text_console_ctrl.sv - randomized self-checking bench for text_console_ctrl
`ifndef DP_REG_WIDTH
`define DP_REG_WIDTH 16
`endif

module tb_text_console_ctrl;
   localparam int NC = 80;
   localparam int NR = 30;
   localparam int W  = `DP_REG_WIDTH;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         ch_valid = 1'b0;
   logic [7:0]   ch_data = 8'h00;
   logic         ch_ready;
   logic [7:0]   attr = 8'h00;
   logic         clr_req = 1'b0;
   logic         busy;
   logic         vram_we;
   logic [7:0]   vram_x;
   logic [4:0]   vram_y;
   logic [15:0]  vram_wdata;
   logic         vram_re;
   logic [7:0]   vram_rx;
   logic [4:0]   vram_ry;
   logic [15:0]  vram_rdata;
   logic [W-1:0] ctrl_reg;

   text_console_ctrl dut (
      .clk(clk), .reset_n(reset_n), .ch_valid(ch_valid), .ch_data(ch_data),
      .ch_ready(ch_ready), .attr(attr), .clr_req(clr_req), .busy(busy),
      .vram_we(vram_we), .vram_x(vram_x), .vram_y(vram_y), .vram_wdata(vram_wdata),
      .vram_re(vram_re), .vram_rx(vram_rx), .vram_ry(vram_ry), .vram_rdata(vram_rdata),
      .ctrl_reg(ctrl_reg)
   );

   always #5 clk = ~clk;

   logic [15:0] mem  [0:NR-1][0:NC-1];
   logic [15:0] pat  [0:NR-1][0:NC-1];
   logic [15:0] expm [0:NR-1][0:NC-1];
   logic        preload = 1'b0;

   always @(posedge clk) begin
      if (preload) begin
         for (int y = 0; y < NR; y++)
            for (int x = 0; x < NC; x++)
               mem[y][x] <= pat[y][x];
      end else if (vram_we && vram_x < NC && vram_y < NR) begin
         mem[vram_y][vram_x] <= vram_wdata;
      end
      if (vram_re && vram_rx < NC && vram_ry < NR)
         vram_rdata <= mem[vram_ry][vram_rx];
   end

   typedef struct {
      bit          rd;
      int          x;
      int          y;
      logic [15:0] d;
   } op_t;

   op_t         ops[$];
   int          checks = 0;
   int          errors = 0;
   int          pos = 0;
   int          last_wait = 0;
   logic [15:0] obs_wd;

   function automatic logic [W-1:0] cur_ctrl();
      return W'({5'(pos / NC), 8'(pos % NC)});
   endfunction

   task automatic model_put(input logic [7:0] b, input logic [7:0] a, output bit we,
                            output int wx, output int wy, output logic [15:0] wd, output bit scr);
      we = 0; scr = 0; wx = 0; wy = 0; wd = '0;
      case (b)
         8'h0D: pos = (pos / NC) * NC;
         8'h0A: begin
            pos = (pos / NC + 1) * NC;
            if (pos == NC * NR) begin scr = 1; pos = NC * (NR - 1); end
         end
         8'h08: if (pos > 0) begin
            pos = pos - 1;
            we = 1; wx = pos % NC; wy = pos / NC; wd = {a, 8'h20};
         end
         default: begin
            we = 1; wx = pos % NC; wy = pos / NC; wd = {a, b};
            pos = pos + 1;
            if (pos == NC * NR) begin scr = 1; pos = NC * (NR - 1); end
         end
      endcase
      if (we) expm[wy][wx] = wd;
   endtask

   task automatic run_ops(input string name, input int want);
      int  cyc = 0;
      int  bad = 0;
      int  first = -1;
      bit  ok;
      op_t o;
      while (busy === 1'b1 && cyc < 6000) begin
         ok = 0;
         if (cyc < ops.size()) begin
            o = ops[cyc];
            if (o.rd)
               ok = (vram_re === 1'b1 && vram_we === 1'b0 &&
                     vram_rx === 8'(o.x) && vram_ry === 5'(o.y));
            else
               ok = (vram_we === 1'b1 && vram_re === 1'b0 && vram_x === 8'(o.x) &&
                     vram_y === 5'(o.y) && vram_wdata === o.d);
         end
         if (!ok) begin
            bad++;
            if (first < 0) first = cyc;
         end
         cyc++;
         @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL %s_seq bad_cycles=%0d first_bad_cycle=%0d required 0", name, bad, first);
      end
      checks++;
      if (cyc != want) begin
         errors++;
         $display("FAIL %s_busy_cycles got %0d required %0d", name, cyc, want);
      end
   endtask

   task automatic check_scroll(input logic [7:0] a);
      ops.delete();
      for (int r = 1; r < NR; r++)
         for (int x = 0; x < NC; x++) begin
            ops.push_back('{rd: 1'b1, x: x, y: r, d: 16'h0});
            ops.push_back('{rd: 1'b0, x: x, y: r - 1, d: expm[r][x]});
         end
      for (int x = 0; x < NC; x++)
         ops.push_back('{rd: 1'b0, x: x, y: NR - 1, d: {a, 8'h20}});
      run_ops("scroll", 2 * (NR - 1) * NC + NC);
      for (int r = 1; r < NR; r++)
         for (int x = 0; x < NC; x++)
            expm[r - 1][x] = expm[r][x];
      for (int x = 0; x < NC; x++)
         expm[NR - 1][x] = {a, 8'h20};
   endtask

   task automatic send_and_check(input logic [7:0] b, input logic [7:0] a);
      int          w = 0;
      bit          ewe, scr;
      int          ewx, ewy;
      logic [15:0] ewd;
      logic [W-1:0] pre;
      while (ch_ready !== 1'b1 && w < 10000) begin
         @(negedge clk);
         w++;
      end
      last_wait = w;
      checks++;
      if (ch_ready !== 1'b1) begin
         errors++;
         $display("FAIL accept_wait ch_ready=%b required 1", ch_ready);
         return;
      end
      pre = cur_ctrl();
      ch_valid = 1'b1; ch_data = b; attr = a;
      @(negedge clk);
      ch_valid = 1'b0;
      model_put(b, a, ewe, ewx, ewy, ewd, scr);
      obs_wd = vram_wdata;
      checks++;
      if (vram_we !== ewe || vram_re !== 1'b0 || busy !== 1'b1 || ch_ready !== 1'b0) begin
         errors++;
         $display("FAIL put_strobes byte=%h we=%b re=%b busy=%b rdy=%b required we=%b re=0 busy=1 rdy=0",
                  b, vram_we, vram_re, busy, ch_ready, ewe);
      end
      if (ewe) begin
         checks++;
         if (vram_x !== 8'(ewx) || vram_y !== 5'(ewy) || vram_wdata !== ewd) begin
            errors++;
            $display("FAIL put_cell byte=%h got (%0d,%0d) %h required (%0d,%0d) %h",
                     b, vram_x, vram_y, vram_wdata, ewx, ewy, ewd);
         end
      end
      checks++;
      if (ctrl_reg !== pre) begin
         errors++;
         $display("FAIL ctrl_lag got %h required %h", ctrl_reg, pre);
      end
      @(negedge clk);
      if (scr) check_scroll(a);
      checks++;
      if (ctrl_reg !== cur_ctrl() || ch_ready !== 1'b1) begin
         errors++;
         $display("FAIL ctrl_update byte=%h ctrl=%h rdy=%b required ctrl=%h rdy=1",
                  b, ctrl_reg, ch_ready, cur_ctrl());
      end
   endtask

   task automatic do_clear(input logic [7:0] a, input bit with_byte);
      int w = 0;
      while (busy === 1'b1 && w < 10000) begin
         @(negedge clk);
         w++;
      end
      clr_req = 1'b1; attr = a;
      if (with_byte) begin
         ch_valid = 1'b1; ch_data = 8'h5A;
      end
      #1;
      checks++;
      if (ch_ready !== 1'b0) begin
         errors++;
         $display("FAIL clr_blocks_ready got %b required 0", ch_ready);
      end
      @(negedge clk);
      clr_req = 1'b0;
      ops.delete();
      for (int y = 0; y < NR; y++)
         for (int x = 0; x < NC; x++)
            ops.push_back('{rd: 1'b0, x: x, y: y, d: {a, 8'h20}});
      run_ops("clear", NR * NC);
      for (int y = 0; y < NR; y++)
         for (int x = 0; x < NC; x++)
            expm[y][x] = {a, 8'h20};
      pos = 0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, vram_we, vram_re, ch_ready} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outputs busy/we/re/rdy=%b required 0000", {busy, vram_we, vram_re, ch_ready});
      end
      checks++;
      if (ctrl_reg !== '0) begin
         errors++;
         $display("FAIL reset_ctrl got %h required 0", ctrl_reg);
      end
      reset_n = 1'b1;
      #1;
      checks++;
      if (ch_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_release got %b required 1", ch_ready);
      end
      pos = 0;
      @(negedge clk);
   endtask

   task automatic test_single_char();
      send_and_check(8'h41, 8'h1E);
      checks++;
      if (obs_wd !== 16'h1E41) begin
         errors++;
         $display("FAIL first_char_wdata got %h required 1e41", obs_wd);
      end
      checks++;
      if (ctrl_reg !== W'(13'h0001)) begin
         errors++;
         $display("FAIL first_char_ctrl got %h required 0001", ctrl_reg);
      end
   endtask

   task automatic test_clear_with_byte();
      do_clear(8'h4F, 1'b1);
      send_and_check(8'h5A, 8'h4F);
   endtask

   task automatic test_wrap();
      send_and_check(8'h0D, 8'h07);
      repeat (5) send_and_check(8'h0A, 8'h07);
      repeat (79) send_and_check(8'($urandom_range(8'h20, 8'h7E)), 8'($urandom));
      send_and_check(8'h42, 8'h2A);
      checks++;
      if (ctrl_reg !== W'(13'h0600)) begin
         errors++;
         $display("FAIL wrap_ctrl got %h required 0600", ctrl_reg);
      end
   endtask

   task automatic test_backspace();
      do_clear(8'h17, 1'b0);
      repeat (3) send_and_check(8'h0A, 8'h17);
      send_and_check(8'h08, 8'h61);
      checks++;
      if (ctrl_reg !== W'(13'h024F) || obs_wd !== 16'h6120) begin
         errors++;
         $display("FAIL bs_row_wrap ctrl=%h wdata=%h required ctrl=024f wdata=6120", ctrl_reg, obs_wd);
      end
      do_clear(8'h17, 1'b0);
      send_and_check(8'h08, 8'h61);
      checks++;
      if (ctrl_reg !== '0) begin
         errors++;
         $display("FAIL bs_origin_ctrl got %h required 0", ctrl_reg);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) begin
         send_and_check(8'($urandom_range(8'h20, 8'h7E)), 8'($urandom));
         if (i > 0) begin
            checks++;
            if (last_wait != 0) begin
               errors++;
               $display("FAIL b2b_gap got %0d wait cycles required 0", last_wait);
            end
         end
      end
   endtask

   task automatic test_random_stream();
      logic [7:0] b;
      int         k;
      for (int i = 0; i < 200; i++) begin
         k = $urandom_range(0, 11);
         case (k)
            0:       b = 8'h0A;
            1:       b = 8'h0D;
            2, 3:    b = 8'h08;
            default: b = 8'($urandom_range(0, 255));
         endcase
         send_and_check(b, 8'($urandom));
      end
   endtask

   task automatic test_scroll();
      do_clear(8'h07, 1'b0);
      for (int y = 0; y < NR; y++)
         for (int x = 0; x < NC; x++) begin
            pat[y][x]  = 16'($urandom);
            expm[y][x] = pat[y][x];
         end
      preload = 1'b1;
      @(negedge clk);
      preload = 1'b0;
      repeat (NR - 1) send_and_check(8'h0A, 8'h07);
      repeat (10) send_and_check(8'($urandom_range(8'h21, 8'h7E)), 8'($urandom));
      send_and_check(8'h0A, 8'h5B);
      checks++;
      if (ctrl_reg !== W'(13'h1D00)) begin
         errors++;
         $display("FAIL scroll_ctrl got %h required 1d00", ctrl_reg);
      end
   endtask

   task automatic test_vram_image();
      int bad = 0;
      for (int y = 0; y < NR; y++)
         for (int x = 0; x < NC; x++)
            if (mem[y][x] !== expm[y][x]) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL vram_image mismatched_cells=%0d required 0", bad);
      end
   endtask

   task automatic test_reset_mid_scroll();
      int w = 0;
      int nw = 0;
      while (ch_ready !== 1'b1 && w < 10000) begin
         @(negedge clk);
         w++;
      end
      ch_valid = 1'b1; ch_data = 8'h0A; attr = 8'h3C;
      @(negedge clk);
      ch_valid = 1'b0;
      repeat (300) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL scroll_running busy=%b required 1", busy);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({vram_we, vram_re, busy, ch_ready} !== 4'b0000 || ctrl_reg !== '0) begin
         errors++;
         $display("FAIL async_reset we/re/busy/rdy=%b ctrl=%h required 0000 ctrl=0",
                  {vram_we, vram_re, busy, ch_ready}, ctrl_reg);
      end
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      pos = 0;
      #1;
      checks++;
      if (ch_ready !== 1'b1 || busy !== 1'b0 || ctrl_reg !== '0) begin
         errors++;
         $display("FAIL post_reset rdy=%b busy=%b ctrl=%h required rdy=1 busy=0 ctrl=0",
                  ch_ready, busy, ctrl_reg);
      end
      repeat (50) begin
         @(posedge clk);
         #1;
         if (vram_we === 1'b1 || vram_re === 1'b1) nw++;
      end
      checks++;
      if (nw != 0) begin
         errors++;
         $display("FAIL quiet_after_reset vram_cycles=%0d required 0", nw);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_char();
      test_clear_with_byte();
      test_wrap();
      test_backspace();
      test_back_to_back();
      test_random_stream();
      test_scroll();
      test_vram_image();
      test_reset_mid_scroll();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
